// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: segment codes,
// digit count and conversion FSM states.
package seg_pkg;

    localparam int NUM_DIG = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Buffer digit code reserved for the out-of-range dash
    localparam logic [3:0] DIG_DASH = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV_H,
        ST_CONV_M,
        ST_CONV_S,
        ST_COMMIT
    } state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:     code = SEG_0;
            4'd1:     code = SEG_1;
            4'd2:     code = SEG_2;
            4'd3:     code = SEG_3;
            4'd4:     code = SEG_4;
            4'd5:     code = SEG_5;
            4'd6:     code = SEG_6;
            4'd7:     code = SEG_7;
            4'd8:     code = SEG_8;
            4'd9:     code = SEG_9;
            DIG_DASH: code = SEG_DASH;
            default:  code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_driver_bin2bcd.sv
// Sequential 6-bit binary to two-digit BCD converter (double dabble).
// done pulses 7 cycles after start; tens/ones hold until the next start.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [5:0] sh;
    logic [7:0] bcd;
    logic [2:0] cnt;
    logic [3:0] adj_hi;
    logic [3:0] adj_lo;
    logic [7:0] bcd_nxt;

    always_comb begin
        adj_hi  = (bcd[7:4] >= 4'd5) ? 4'(bcd[7:4] + 4'd3) : bcd[7:4];
        adj_lo  = (bcd[3:0] >= 4'd5) ? 4'(bcd[3:0] + 4'd3) : bcd[3:0];
        bcd_nxt = {adj_hi[2:0], adj_lo, sh[5]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            tens <= '0;
            ones <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh   <= bin;
                bcd  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                sh  <= {sh[4:0], 1'b0};
                bcd <= bcd_nxt;
                cnt <= cnt + 3'd1;
                if (cnt == 3'd5) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    tens <= bcd_nxt[7:4];
                    ones <= bcd_nxt[3:0];
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Converts hour/min/sec to a BCD display buffer and scans it onto a
// 6-digit common-anode 7-segment display with anti-ghost blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int BLANK_CYC = 4,
    parameter bit DP_BLINK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       scan_tick,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    state_t     state;
    logic [4:0] hour_q;
    logic [5:0] min_q;
    logic [5:0] sec_q;
    logic [3:0] dig  [NUM_DIG];
    logic [3:0] nxt  [NUM_DIG];
    logic [3:0] view [NUM_DIG];
    logic [3:0] h_t;
    logic [3:0] h_o;
    logic [3:0] m_t;
    logic [3:0] m_o;

    logic       conv_start;
    logic [5:0] conv_bin;
    logic       conv_busy;
    logic       conv_done;
    logic [3:0] conv_tens;
    logic [3:0] conv_ones;

    always_comb begin
        conv_bin = sec_q;
        unique case (1'b1)
            state == ST_CONV_H: conv_bin = {1'b0, hour_q};
            state == ST_CONV_M: conv_bin = min_q;
            default:            conv_bin = sec_q;
        endcase
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    // Seconds digits come straight from the converter, which holds them
    always_comb begin
        nxt[0] = h_t;
        nxt[1] = h_o;
        nxt[2] = m_t;
        nxt[3] = m_o;
        nxt[4] = conv_tens;
        nxt[5] = conv_ones;
        if (hour_q > 5'd23) begin
            nxt[0] = DIG_DASH;
            nxt[1] = DIG_DASH;
        end
        if (min_q > 6'd59) begin
            nxt[2] = DIG_DASH;
            nxt[3] = DIG_DASH;
        end
        if (sec_q > 6'd59) begin
            nxt[4] = DIG_DASH;
            nxt[5] = DIG_DASH;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIG; i++)
            view[i] = (state == ST_COMMIT) ? nxt[i] : dig[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            h_t        <= '0;
            h_o        <= '0;
            m_t        <= '0;
            m_o        <= '0;
            conv_start <= 1'b0;
            for (int i = 0; i < NUM_DIG; i++)
                dig[i] <= '0;
        end else begin
            conv_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ({hour, min, sec} != {hour_q, min_q, sec_q}) begin
                        hour_q     <= hour;
                        min_q      <= min;
                        sec_q      <= sec;
                        conv_start <= 1'b1;
                        state      <= ST_CONV_H;
                    end
                end
                ST_CONV_H: begin
                    if (conv_done) begin
                        h_t        <= conv_tens;
                        h_o        <= conv_ones;
                        conv_start <= 1'b1;
                        state      <= ST_CONV_M;
                    end
                end
                ST_CONV_M: begin
                    if (conv_done) begin
                        m_t        <= conv_tens;
                        m_o        <= conv_ones;
                        conv_start <= 1'b1;
                        state      <= ST_CONV_S;
                    end
                end
                ST_CONV_S: begin
                    if (conv_done)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NUM_DIG; i++)
                        dig[i] <= nxt[i];
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic [BW-1:0] bcnt;
    logic          dp_on;
    logic [7:0]    seg_cur;
    logic [7:0]    seg_nxt;

    function automatic logic [5:0] sel_of(input logic [2:0] i);
        return ~(6'b000001 << i);
    endfunction

    always_comb begin
        idx_nxt = (idx == 3'(NUM_DIG - 1)) ? 3'd0 : 3'(idx + 3'd1);
        dp_on   = !DP_BLINK || !sec_q[0];
        seg_cur = seg_decode(view[idx]);
        seg_nxt = seg_decode(view[idx_nxt]);
        if (dp_on && (idx == 3'd1 || idx == 3'd3))
            seg_cur[7] = 1'b0;
        if (dp_on && (idx_nxt == 3'd1 || idx_nxt == 3'd3))
            seg_nxt[7] = 1'b0;
    end

    // Outside blanking the current digit is refreshed every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            bcnt <= '0;
            sel  <= '1;
            seg  <= SEG_BLANK;
        end else if (scan_tick) begin
            idx <= idx_nxt;
            if (BLANK_CYC > 0) begin
                bcnt <= BW'(BLANK_CYC);
                sel  <= '1;
                seg  <= SEG_BLANK;
            end else begin
                sel <= sel_of(idx_nxt);
                seg <= seg_nxt;
            end
        end else if (bcnt > BW'(1)) begin
            bcnt <= bcnt - BW'(1);
        end else begin
            bcnt <= '0;
            sel  <= sel_of(idx);
            seg  <= seg_cur;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expected digit outputs are
// queued per stimulus and popped as each scanned digit appears.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       scan_tick;
    logic [5:0] sel;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;
    int tidx   = 0;

    typedef struct {
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    seg_scan_driver #(
        .BLANK_CYC (4),
        .DP_BLINK  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .scan_tick (scan_tick),
        .sel       (sel),
        .seg       (seg)
    );

    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] code_of(input int v);
        case (v)
            0:  return 8'hC0;
            1:  return 8'hF9;
            2:  return 8'hA4;
            3:  return 8'hB0;
            4:  return 8'h99;
            5:  return 8'h92;
            6:  return 8'h82;
            7:  return 8'hF8;
            8:  return 8'h80;
            9:  return 8'h90;
            10: return 8'hBF;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int h, input int m,
                                           input int s, input int d);
        int v[6];
        logic [7:0] c;
        v[0] = h / 10; v[1] = h % 10;
        v[2] = m / 10; v[3] = m % 10;
        v[4] = s / 10; v[5] = s % 10;
        if (h > 23) begin v[0] = 10; v[1] = 10; end
        if (m > 59) begin v[2] = 10; v[3] = 10; end
        if (s > 59) begin v[4] = 10; v[5] = 10; end
        c = code_of(v[d]);
        if ((d == 1 || d == 3) && (s % 2 == 0))
            c[7] = 1'b0;
        return c;
    endfunction

    function automatic logic [5:0] exp_sel(input int d);
        logic [5:0] one;
        one = 6'b000001;
        return ~(one << d);
    endfunction

    task automatic push_round(input int h, input int m, input int s);
        exp_t e;
        int d;
        for (int k = 0; k < 6; k++) begin
            d = (tidx + 1 + k) % 6;
            e.sel = exp_sel(d);
            e.seg = exp_seg(h, m, s, d);
            sb.push_back(e);
        end
    endtask

    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk); #1 scan_tick = 1'b1;
        @(posedge clk); #1 scan_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("%s_blank%0d", tag, i), {sel, seg}, {6'h3F, 8'hFF});
        end
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: scoreboard empty, got sel %0h seg %0h",
                     tag, sel, seg);
        end else begin
            e = sb.pop_front();
            chk($sformatf("%s_sel", tag), sel, e.sel);
            chk($sformatf("%s_seg", tag), seg, e.seg);
        end
        tidx = (tidx + 1) % 6;
    endtask

    task automatic scan_round(input string tag);
        for (int k = 0; k < 6; k++)
            tick_check($sformatf("%s_t%0d", tag, k));
    endtask

    task automatic apply(input int h, input int m, input int s);
        @(posedge clk); #1;
        hour = 5'(h);
        min  = 6'(m);
        sec  = 6'(s);
    endtask

    int vec[6][3] = '{
        '{12, 34, 57},
        '{25,  0,  0},
        '{23, 59, 59},
        '{ 0, 60, 58},
        '{31, 63, 63},
        '{ 9,  5, 60}
    };

    initial begin
        rst       = 1'b1;
        hour      = '0;
        min       = '0;
        sec       = '0;
        scan_tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", {sel, seg}, {6'h3F, 8'hFF});
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_sel", sel, 6'h3E);
        chk("idle_seg", seg, 8'hC0);
        repeat (30) @(posedge clk);
        push_round(0, 0, 0);
        scan_round("zero");

        // Buffer swap must appear exactly in cycle t+26
        apply(12, 34, 56);
        repeat (26) @(negedge clk);
        chk("t25_old", seg, exp_seg(0, 0, 0, tidx));
        @(negedge clk);
        chk("t26_new", seg, exp_seg(12, 34, 56, tidx));
        push_round(12, 34, 56);
        scan_round("t123456");

        foreach (vec[i]) begin
            apply(vec[i][0], vec[i][1], vec[i][2]);
            repeat (30) @(posedge clk);
            push_round(vec[i][0], vec[i][1], vec[i][2]);
            scan_round($sformatf("v%0d", i));
        end

        // Reset in the middle of a conversion
        apply(7, 8, 9);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("midrst_out", {sel, seg}, {6'h3F, 8'hFF});
        @(posedge clk); #1 rst = 1'b0;
        tidx = 0;
        @(posedge clk);
        @(negedge clk);
        chk("postrst_sel", sel, 6'h3E);
        chk("postrst_seg", seg, 8'hC0);
        repeat (30) @(posedge clk);
        push_round(7, 8, 9);
        scan_round("reconv");

        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Display-side consumer of the time-of-day counter outputs (hour/min/sec plus the periodic scan tick). It converts the three binary fields to BCD with a shared sequential converter and holds the result in a 6-digit display buffer. It then time-multiplexes a 6-digit common-anode 7-segment display, HH.MM.SS, one digit per scan tick. The block sits between the time counter and the board seg/sel pins.

Parameters:
BLANK_CYC, 4, clk cycles with all digits deselected after each digit switch (anti-ghosting); 0 disables blanking.
DP_BLINK, 1, 1: separator dots lit only while latched sec is even; 0: dots always lit.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
hour  input  5  binary hours; valid range 0..23
min  input  6  binary minutes; valid range 0..59
sec  input  6  binary seconds; valid range 0..59
scan_tick  input  1  one-cycle pulse that advances the digit scan
sel  output  6  digit enables, active-low; sel[i] drives digit i, where digit 0 is hour tens (leftmost)
seg  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (async, active-high) sets:
  - sel=6'b111111, seg=8'hFF;
  - digit index=0, blank counter=0;
  - FSM=IDLE;
  - last-converted triple=0, display buffer=all digits 0.
- Change detect (IDLE only): if {hour,min,sec} differs from the last-converted triple in cycle t, latch the triple and go to CONV_H in cycle t+1. Input changes during a conversion are ignored until the FSM is back in IDLE.
- FSM states: IDLE -> CONV_H -> CONV_M -> CONV_S -> COMMIT -> IDLE.
  - Each CONV state pulses start to the converter for one cycle on entry, then waits for done.
  - Timing: CONV_H start t+1, done t+8; CONV_M start t+9, done t+16; CONV_S start t+17, done t+24.
  - COMMIT in t+25 writes the buffer; the new buffer is visible from t+26.
- Range check at COMMIT, per field:
  - hour>23, min>59 or sec>59 -> both digits of that field store the dash code.
  - Other fields are unaffected.
- Scan:
  - On scan_tick, index advances 0..5 and wraps 5->0.
  - If BLANK_CYC>0: sel=all-1 and seg=8'hFF for BLANK_CYC cycles, then sel[index]=0 and seg=the decoded buffer digit.
  - If BLANK_CYC=0: new sel/seg are registered in the cycle after the tick.
  - A tick arriving during blanking restarts blanking and advances the index again.
- Decimal point: seg[7]=0 on digits 1 and 3 when the dots are enabled (see DP_BLINK, evaluated on the latched sec LSB).
- Buffer write while a digit is being displayed: seg updates in the cycle after COMMIT. This is glitch-free per digit; no tearing rule applies.
- Segment codes (hex, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF, blank=FF.
- Reset mid-conversion aborts the conversion: the buffer returns to zeros and the FSM to IDLE.

Decomposition:
- Shared package seg_pkg holds:
  - the segment code constants;
  - the digit count constant NUM_DIG=6;
  - FSM state encodings.
- One sub-module, bin2bcd_seq: 6-bit binary in, tens[3:0]/ones[3:0] out, start/busy/done.
  - Shift-add-3 (double dabble) over 6 iterations.
  - done is a one-cycle pulse exactly 7 cycles after start, with outputs held stable until the next start.
  - hour is zero-extended to 6 bits.

Test Plan:
- Reset with inputs 0, ticks running -> buffer digits 000000; digit0 shows seg=C0; digit1 shows seg=40 (dp lit, sec even); no conversion is started.
- hour=12, min=34, sec=56 applied at cycle t -> buffer 1,2,3,4,5,6 visible at t+26; scanning returns seg F9, 24, B0, 19, 92, 82 on digits 0..5.
- sec changes to 57 -> dots clear; digit1 seg=A4, digit3 seg=99.
- hour=25 (out of range), min=0, sec=0 -> digits 0-1 show BF/3F; minutes and seconds show 0.
- BLANK_CYC=4 -> after each tick, sel=111111 for exactly 4 cycles, then a single low bit. Index wrap: after digit 5 the next tick selects digit 0 (sel=111110).
- Assert rst at t+12 of a conversion -> sel/seg return to inactive immediately; after release the FSM is IDLE and the buffer is 000000. It then re-detects the input and converts.
